// File: rtl/tpu_job_seq_if.sv
// MMIO request/response bus between the job sequencer (master) and tpu_top (slave).
// A request is held stable until the cycle mmio_ready is high, and that cycle completes it.
interface tpu_job_seq_if;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;

  modport master (
    output mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb,
    input  mmio_rdata, mmio_ready
  );

  modport slave (
    input  mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb,
    output mmio_rdata, mmio_ready
  );
endinterface

// File: rtl/tpu_job_seq.sv
// Runs one matmul job on tpu_top over MMIO.
// The flow is: stream in the A and B operands, write START, poll STATUS until DONE,
// then read the C sums back out onto a result stream.
// Every output comes straight from a register, so mmio_ready never reaches an output combinationally.
module tpu_job_seq #(
  parameter int          N         = 4,
  parameter int          DATA_W    = 8,
  parameter int          SUM_W     = 32,
  parameter logic [15:0] CTRL_ADDR = 16'h0000,
  parameter logic [15:0] STAT_ADDR = 16'h0004,
  parameter logic [15:0] A_BASE    = 16'h0100,
  parameter logic [15:0] B_BASE    = 16'h0200,
  parameter logic [15:0] C_BASE    = 16'h0300,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              job_done,
  output logic              err,
  tpu_job_seq_if.master     mmio
);

  localparam int NN = N * N;
  localparam int KW = $clog2(2 * NN + 1);
  localparam int JW = $clog2(NN + 1);
  localparam int PW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_KICK = 3'd2;
  localparam logic [2:0] S_POLL = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_PUSH = 3'd5;

  logic [2:0]        state_q,     state_d;
  logic [KW-1:0]     k_q,         k_d;
  logic [JW-1:0]     j_q,         j_d;
  logic [PW-1:0]     poll_q,      poll_d;
  logic              wr_q,        wr_d;
  logic              rd_q,        rd_d;
  logic [15:0]       addr_q,      addr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_data_q,  out_data_d;
  logic              err_q,       err_d;
  logic              job_done_q,  job_done_d;

  // Word-aligned register address of element idx in a buffer.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input int idx);
    return base + 16'(idx * 4);
  endfunction

  // Next-state logic: one MMIO request outstanding at most, each held until mmio_ready.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    j_d         = j_q;
    poll_d      = poll_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    job_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The element is only noticed here; LOAD consumes it.
        if (in_valid) begin
          state_d = S_LOAD;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (wr_q) begin
          if (mmio.mmio_ready) begin
            wr_d = 1'b0;
            if (k_q == KW'(2 * NN - 1)) state_d = S_KICK;
            else                        k_d     = k_q + 1'b1;
          end
        end else if (in_valid) begin
          wr_d    = 1'b1;
          wdata_d = 32'(in_data);
          addr_d  = (int'(k_q) < NN) ? word_addr(A_BASE, int'(k_q))
                                     : word_addr(B_BASE, int'(k_q) - NN);
        end
      end

      S_KICK: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = CTRL_ADDR;
          wdata_d = 32'h1;
        end else if (mmio.mmio_ready) begin
          wr_d    = 1'b0;
          poll_d  = '0;
          state_d = S_POLL;
        end
      end

      S_POLL: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = STAT_ADDR;
        end else if (mmio.mmio_ready) begin
          if (mmio.mmio_rdata[1]) begin
            // Back-to-back: the first C read goes out on the next cycle.
            state_d = S_READ;
            j_d     = '0;
            addr_d  = C_BASE;
          end else if (poll_q == PW'(TIMEOUT - 1)) begin
            rd_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            rd_d   = 1'b0;
            poll_d = poll_q + 1'b1;
          end
        end
      end

      S_READ: begin
        if (mmio.mmio_ready) begin
          rd_d        = 1'b0;
          out_data_d  = mmio.mmio_rdata[SUM_W-1:0];
          out_valid_d = 1'b1;
          state_d     = S_PUSH;
        end
      end

      S_PUSH: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (j_q == JW'(NN - 1)) begin
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            j_d     = j_q + 1'b1;
            rd_d    = 1'b1;
            addr_d  = word_addr(C_BASE, int'(j_q) + 1);
            state_d = S_READ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts a job at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      j_q         <= '0;
      poll_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      poll_q      <= poll_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      job_done_q  <= job_done_d;
    end
  end

  assign in_ready        = (state_q == S_LOAD) && !wr_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_last        = out_valid_q && (j_q == JW'(NN - 1));
  assign busy            = (state_q != S_IDLE);
  assign job_done        = job_done_q;
  assign err             = err_q;
  assign mmio.mmio_wr    = wr_q;
  assign mmio.mmio_rd    = rd_q;
  assign mmio.mmio_addr  = addr_q;
  assign mmio.mmio_wdata = wdata_q;
  assign mmio.mmio_wstrb = wr_q ? 4'hF : 4'h0;

endmodule
